// File: rtl/pipe_hazard_ctrl.sv
// Purpose : central stall/flush controller for a 5-stage pipeline (load-use, taken branch, data-memory wait, timeout)
// Latency : control outputs are combinational from state and inputs; state/err/counters update on the next posedge
// Backpr. : a data-memory wait freezes PC and IF/ID..EX/MEM and bubbles MEM/WB until dm_ready_i, or latches ERR after MAX_WAIT WAIT cycles
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ID_rs_i, ID_rt_i, ID_use_rt_i source operands of the instruction in ID
//   EX_memread_i, EX_rt_i         load in EX and its destination register
//   EX_br_taken_i                 branch/jump resolved taken in EX
//   MEM_dmreq_i, dm_ready_i       data-memory access in MEM and its completion
//   pc_write_o .. MEMWB_bubble_o  pipeline enables / flushes / bubble
//   err_o, state_o, stall_cnt_o   sticky timeout error, FSM state, saturating stall counter
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_rs_i,
    input  logic [REG_AW-1:0] ID_rt_i,
    input  logic              ID_use_rt_i,
    input  logic              EX_memread_i,
    input  logic [REG_AW-1:0] EX_rt_i,
    input  logic              EX_br_taken_i,
    input  logic              MEM_dmreq_i,
    input  logic              dm_ready_i,
    output logic              pc_write_o,
    output logic              IFID_write_o,
    output logic              IFID_flush_o,
    output logic              IDEX_write_o,
    output logic              IDEX_flush_o,
    output logic              EXMEM_write_o,
    output logic              MEMWB_bubble_o,
    output logic              err_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic mstl;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu = EX_memread_i && (EX_rt_i != '0) &&
                ((EX_rt_i == ID_rs_i) || (ID_use_rt_i && (EX_rt_i == ID_rt_i)));
    assign mstl = MEM_dmreq_i && !dm_ready_i;

    // Unmasked control decisions; reset masking is applied at the outputs.
    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b;

    always_comb begin
        pc_w       = 1'b1;
        ifid_w     = 1'b1;
        ifid_f     = 1'b0;
        idex_w     = 1'b1;
        idex_f     = 1'b0;
        exmem_w    = 1'b1;
        memwb_b    = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            ST_RUN: begin
                if (mstl) begin
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    idex_w     = 1'b0;
                    exmem_w    = 1'b0;
                    memwb_b    = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end else if (EX_br_taken_i) begin
                    // Flush beats load-use: the stalled instruction is on the wrong path anyway.
                    ifid_f = 1'b1;
                    idex_f = 1'b1;
                end else if (lu) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_f = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!dm_ready_i) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    exmem_w = 1'b0;
                    memwb_b = 1'b1;
                    // wait_cnt counts freeze cycles already spent, including the entry cycle.
                    if (wait_cnt_q == WCW'(MAX_WAIT)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end else begin
                    // Release cycle behaves like RUN without the memory-stall term.
                    if (EX_br_taken_i) begin
                        ifid_f = 1'b1;
                        idex_f = 1'b1;
                    end else if (lu) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        idex_f = 1'b1;
                    end
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERR: begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                idex_w  = 1'b0;
                exmem_w = 1'b0;
                memwb_b = 1'b1;
                err_d   = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Counter sees the unmasked pc enable; reset clears it in the register anyway.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_write_o     = pc_w    && !rst_i;
    assign IFID_write_o   = ifid_w  && !rst_i;
    assign IFID_flush_o   = ifid_f  && !rst_i;
    assign IDEX_write_o   = idex_w  && !rst_i;
    assign IDEX_flush_o   = idex_f  && !rst_i;
    assign EXMEM_write_o  = exmem_w && !rst_i;
    assign MEMWB_bubble_o = memwb_b && !rst_i;
    assign err_o          = err_q;
    assign state_o        = state_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl (default build plus a CNT_W=4 build sharing inputs)
// Latency : one stimulus vector per clock, outputs sampled 1 time unit after the falling edge
// Backpr. : n/a; every wait is bounded by a global watchdog
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rt, ex_memread, ex_br, mem_dmreq, dm_ready;

    logic       pc_a, ifidw_a, ifidf_a, idexw_a, idexf_a, exmemw_a, bub_a, err_a;
    logic [1:0] st_a;
    logic [15:0] cnt_a;
    logic       pc_b, ifidw_b, ifidf_b, idexw_b, idexf_b, exmemw_b, bub_b, err_b;
    logic [1:0] st_b;
    logic [3:0] cnt_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk_i(clk), .rst_i(rst),
        .ID_rs_i(id_rs), .ID_rt_i(id_rt), .ID_use_rt_i(id_use_rt),
        .EX_memread_i(ex_memread), .EX_rt_i(ex_rt), .EX_br_taken_i(ex_br),
        .MEM_dmreq_i(mem_dmreq), .dm_ready_i(dm_ready),
        .pc_write_o(pc_a), .IFID_write_o(ifidw_a), .IFID_flush_o(ifidf_a),
        .IDEX_write_o(idexw_a), .IDEX_flush_o(idexf_a), .EXMEM_write_o(exmemw_a),
        .MEMWB_bubble_o(bub_a), .err_o(err_a), .state_o(st_a), .stall_cnt_o(cnt_a)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .ID_rs_i(id_rs), .ID_rt_i(id_rt), .ID_use_rt_i(id_use_rt),
        .EX_memread_i(ex_memread), .EX_rt_i(ex_rt), .EX_br_taken_i(ex_br),
        .MEM_dmreq_i(mem_dmreq), .dm_ready_i(dm_ready),
        .pc_write_o(pc_b), .IFID_write_o(ifidw_b), .IFID_flush_o(ifidf_b),
        .IDEX_write_o(idexw_b), .IDEX_flush_o(idexf_b), .EXMEM_write_o(exmemw_b),
        .MEMWB_bubble_o(bub_b), .err_o(err_b), .state_o(st_b), .stall_cnt_o(cnt_b)
    );

    // Control vector order: {pc, IFID_w, IFID_f, IDEX_w, IDEX_f, EXMEM_w, MEMWB_bubble}
    localparam logic [6:0] C_RST = 7'b0000000;
    localparam logic [6:0] C_ADV = 7'b1101010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2;

    typedef struct {
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [15:0] exp_c16;
    logic [3:0]  exp_c4;
    string cur_test = "init";

    // Scoreboard consumer: compares the entry pushed for the current cycle.
    initial begin
        exp_t  e;
        string n;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                n   = nm_q.pop_front();
                act = {pc_a, ifidw_a, ifidf_a, idexw_a, idexf_a, exmemw_a, bub_a};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b want %b", n, act, e.ctrl);
                end
                checks++;
                if (st_a !== e.st) begin
                    errors++;
                    $display("FAIL %s state: got %0d want %0d", n, st_a, e.st);
                end
                checks++;
                if (err_a !== (e.st == S_ERR)) begin
                    errors++;
                    $display("FAIL %s err: got %b want %b", n, err_a, (e.st == S_ERR));
                end
                checks++;
                if (cnt_a !== e.c16) begin
                    errors++;
                    $display("FAIL %s stall_cnt16: got %0d want %0d", n, cnt_a, e.c16);
                end
                checks++;
                if (cnt_b !== e.c4) begin
                    errors++;
                    $display("FAIL %s stall_cnt4: got %0d want %0d", n, cnt_b, e.c4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus (called at a falling edge) and push its expectation.
    task automatic drive(input logic r, input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic dq, input logic rdy,
                         input logic [6:0] ec, input logic [1:0] es, input string tag);
        exp_t e;
        rst = r; ex_memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        id_use_rt = urt; ex_br = br; mem_dmreq = dq; dm_ready = rdy;
        e.ctrl = ec; e.st = es; e.c16 = exp_c16; e.c4 = exp_c4;
        sb_q.push_back(e);
        nm_q.push_back({cur_test, ":", tag});
        @(posedge clk);
        if (r) begin
            exp_c16 = '0;
            exp_c4  = '0;
        end else if (!ec[6]) begin
            if (exp_c16 != 16'hFFFF) exp_c16 = exp_c16 + 16'd1;
            if (exp_c4 != 4'hF)      exp_c4  = exp_c4 + 4'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [6:0] ec, input logic [1:0] es, input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ec, es, tag);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, S_RUN, "idle_in_reset");
        drive(1, 1, 5, 5, 0, 0, 1, 1, 0, C_RST, S_RUN, "forced_in_reset");
        idle(C_ADV, S_RUN, "first_run");
    endtask

    task automatic test_load_use();
        cur_test = "load_use";
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0, C_LU, S_RUN, "rs_hit");
        idle(C_ADV, S_RUN, "after_bubble");
    endtask

    task automatic test_rt_and_zero();
        cur_test = "rt_zero";
        drive(0, 1, 5, 3, 5, 0, 0, 0, 0, C_ADV, S_RUN, "rt_unused");
        drive(0, 1, 5, 3, 5, 1, 0, 0, 0, C_LU,  S_RUN, "rt_used");
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, C_ADV, S_RUN, "r0_rs");
        drive(0, 1, 0, 7, 0, 1, 0, 0, 0, C_ADV, S_RUN, "r0_rt");
        drive(0, 0, 5, 5, 5, 1, 0, 0, 0, C_ADV, S_RUN, "no_load");
    endtask

    task automatic test_branch_lu();
        cur_test = "branch";
        drive(0, 1, 5, 5, 0, 0, 1, 0, 0, C_BR, S_RUN, "br_plus_lu");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR, S_RUN, "br_only");
        idle(C_ADV, S_RUN, "after_br");
    endtask

    task automatic test_mem_wait();
        cur_test = "mem_wait";
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, C_ADV, S_RUN,  "zero_wait");
        drive(0, 1, 5, 5, 0, 0, 1, 1, 0, C_FRZ, S_RUN,  "enter_prio");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_WAIT, "wait2");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_WAIT, "wait3");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, C_ADV, S_WAIT, "release");
        idle(C_ADV, S_RUN, "back_run");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_RUN,  "enter_b");
        drive(0, 1, 5, 5, 0, 0, 1, 1, 1, C_BR,  S_WAIT, "release_br");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_RUN,  "enter_l");
        drive(0, 1, 9, 2, 9, 1, 0, 1, 1, C_LU,  S_WAIT, "release_lu");
        idle(C_ADV, S_RUN, "done");
    endtask

    task automatic test_timeout();
        cur_test = "timeout";
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_RUN, "enter");
        for (int i = 1; i <= 15; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_WAIT, $sformatf("wait%0d", i));
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_ERR, "err1");
        drive(0, 1, 5, 5, 0, 0, 1, 1, 1, C_FRZ, S_ERR, "err_ready");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, S_ERR, "err_idle");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, S_ERR, "reset_from_err");
        idle(C_ADV, S_RUN, "after_reset");
    endtask

    task automatic test_reset_mid_wait();
        cur_test = "rst_wait";
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_RUN,  "enter");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, S_WAIT, "wait_c2");
        drive(1, 1, 5, 5, 0, 0, 1, 1, 0, C_RST, S_WAIT, "in_reset");
        idle(C_ADV, S_RUN, "after_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, C_ADV, S_RUN, "zero_wait");
    endtask

    task automatic test_saturate();
        cur_test = "saturate";
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, S_RUN, "clear");
        for (int i = 0; i < 20; i++)
            drive(0, 1, 6, 6, 0, 0, 0, 0, 0, C_LU, S_RUN, $sformatf("lu%0d", i));
        idle(C_ADV, S_RUN, "final");
    endtask

    initial begin
        exp_c16 = '0; exp_c4 = '0;
        rst = 1'b1; ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        id_use_rt = 0; ex_br = 0; mem_dmreq = 0; dm_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_rt_and_zero();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturate();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
